// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg: default constants and sizing helpers for the ce_gen clock-enable generator.
package ce_gen_pkg;
  localparam int FCLK_DEF   = 50_000_000;
  localparam int F_BASE_DEF = 1000;
  localparam int RATIO_DEF  = 10;
  localparam int NCH_DEF    = 4;
  localparam int D0_DEF     = FCLK_DEF / F_BASE_DEF;
  function automatic int scnt_w(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction
  function automatic int calc_d0(input int fclk, input int f_base);
    return (fclk / f_base < 1) ? 1 : fclk / f_base;
  endfunction
endpackage

// File: rtl/ce_casc_stage.sv
// ce_casc_stage: one decade-style cascade stage passing every RATIO-th input strobe.
module ce_casc_stage
  import ce_gen_pkg::*;
#(
  parameter int RATIO = RATIO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ce_in,
  output logic ce_out
);
  localparam int W = scnt_w(RATIO);
  localparam logic [W-1:0] LAST = W'(RATIO - 1);
  logic [W-1:0] scnt;
  assign ce_out = ce_in & (scnt == LAST);
  always_ff @(posedge clk)
    if (!rst_n || clr) scnt <= '0;
    else if (ce_in) scnt <= ce_out ? '0 : scnt + 1'b1;
endmodule

// File: rtl/ce_gen.sv
// ce_gen: base-rate strobe plus NCH-1 cascaded slower strobes; runtime divisor reload
// when CE_GEN_LOAD_EN is defined.
module ce_gen
  import ce_gen_pkg::*;
#(
  parameter int FCLK   = FCLK_DEF,
  parameter int F_BASE = F_BASE_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int RATIO  = RATIO_DEF,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
`ifdef CE_GEN_LOAD_EN
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
`endif
  output logic [NCH-1:0]   ce
);
  localparam logic [DIV_W-1:0] D0 = DIV_W'(calc_d0(FCLK, F_BASE));
  logic [DIV_W-1:0] bcnt, rld;
  logic [NCH-1:0] c;
  assign c[0] = rst_n & en & ~clr & (bcnt == '0);
  assign ce = c;
`ifdef CE_GEN_LOAD_EN
  logic [DIV_W-1:0] d, shadow;
  // A pending shadow takes effect only at a reload, so phase is never broken.
  assign rld = div_pending ? shadow : d;
  always_ff @(posedge clk)
    if (!rst_n) begin
      d <= D0;
      shadow <= '0;
      div_pending <= 1'b0;
    end else begin
      if (clr || c[0]) d <= rld;
      if (div_load) shadow <= (div_in == '0) ? DIV_W'(1) : div_in;
      div_pending <= div_load | (div_pending & ~(clr | c[0]));
    end
`else
  assign rld = D0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) bcnt <= D0 - 1'b1;
    else if (clr || c[0]) bcnt <= rld - 1'b1;
    else if (en) bcnt <= bcnt - 1'b1;
  for (genvar g = 1; g < NCH; g++) begin : g_stage
    ce_casc_stage #(.RATIO(RATIO)) u_stage (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ce_in(c[g-1]), .ce_out(c[g])
    );
  end
endmodule

// File: tb/tb_ce_gen.sv
// tb_ce_gen: directed plus random stimulus checked against an elapsed-cycle / pulse-count model.
module tb_ce_gen;
  localparam int R = 10, N = 3, W = 16;
`ifdef CE_GEN_LOAD_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif
  logic clk = 1'b0, rst_n, en, clr, div_load;
  logic [W-1:0] div_in;
  logic [N-1:0] ce;
  logic pend_obs;
  int errors = 0, checks = 0, cyc = 0;
  int first [N];
  int last0 = -1, prev0 = -1, tc;
  int m_el = 0, m_d = 10, m_np = 0, m_sh = 0;
  bit m_pend = 1'b0;
  always #5 clk = ~clk;
`ifdef CE_GEN_LOAD_EN
  logic div_pending;
  assign pend_obs = div_pending;
  ce_gen #(.FCLK(1000), .F_BASE(100), .NCH(N), .RATIO(R), .DIV_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .div_in(div_in), .div_load(div_load), .div_pending(div_pending), .ce(ce)
  );
`else
  assign pend_obs = 1'b0;
  ce_gen #(.FCLK(1000), .F_BASE(100), .NCH(N), .RATIO(R), .DIV_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ce(ce)
  );
`endif
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic arm();
    for (int k = 0; k < N; k++) first[k] = -1;
  endtask
  task automatic step(input logic r, input logic e, input logic c, input logic l, input int di);
    logic [N-1:0] exp_ce;
    bit f0, rl, ld;
    int p;
    rst_n = r; en = e; clr = c; div_load = l; div_in = W'(di);
    ld = l & LD;
    @(negedge clk);
    f0 = r && !c && e && (m_el + 1 == m_d);
    exp_ce = '0;
    p = 1;
    for (int k = 0; k < N; k++) begin
      exp_ce[k] = f0 && ((m_np + 1) % p == 0);
      p *= R;
    end
    check("ce", int'(ce), int'(exp_ce));
    check("div_pending", int'(pend_obs), int'(m_pend));
    for (int k = 0; k < N; k++) if (ce[k] && first[k] < 0) first[k] = cyc;
    if (ce[0]) begin prev0 = last0; last0 = cyc; end
    @(posedge clk);
    if (!r) begin
      m_el = 0; m_d = 10; m_np = 0; m_sh = 0; m_pend = 1'b0;
    end else begin
      rl = c | f0;
      if (c) begin m_el = 0; m_np = 0; end
      else if (f0) begin m_el = 0; m_np++; end
      else if (e) m_el++;
      if (rl && m_pend) m_d = m_sh;
      m_pend = ld | (m_pend & !rl);
      if (ld) m_sh = (di == 0) ? 1 : di;
    end
    #1;
    cyc++;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_in = '0;
    @(posedge clk); #1;
    repeat (3) step(0, 1, 0, 0, 0);
    arm();
    repeat (1005) step(1, 1, 0, 0, 0);
    check("first_ce0", first[0], 12);
    check("first_ce1", first[1], 102);
    check("first_ce2", first[2], 1002);
    repeat (5) step(1, 0, 0, 0, 0);
    repeat (30) step(1, 1, 0, 0, 0);
    arm();
    tc = cyc;
    step(1, 1, 1, 0, 0);
    repeat (1005) step(1, 1, 0, 0, 0);
    check("clr_ce0", first[0], tc + 10);
    check("clr_ce1", first[1], tc + 100);
    check("clr_ce2", first[2], tc + 1000);
    step(1, 1, 0, 1, 4);
    repeat (40) step(1, 1, 0, 0, 0);
    check("gap_load4", last0 - prev0, LD ? 4 : 10);
    step(1, 1, 0, 1, 0);
    repeat (30) step(1, 1, 0, 0, 0);
    check("gap_load0", last0 - prev0, LD ? 1 : 10);
    step(1, 1, 0, 1, 7);
    step(1, 1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    tc = cyc - 1;
    arm();
    repeat (25) step(1, 1, 0, 0, 0);
    check("rst_ce0", first[0], tc + 10);
    check("rst_gap", last0 - prev0, 10);
    repeat (3000)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 12));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
